// File: rtl/sobel_pkg.sv
// Shared types for the Sobel frame sequencer: block/plane/state encodings and lane geometry.
package sobel_pkg;

  localparam int PIX_PER_BLK = 16;
  localparam int PIX_W       = 8;

  typedef bit [127:0] block_t;

  typedef enum logic [1:0] {
    RED   = 2'd0,
    GREEN = 2'd1,
    BLUE  = 2'd2
  } plane_e;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    GATHER      = 3'd1,
    WAIT_CREDIT = 3'd2,
    ISSUE       = 3'd3,
    DRAIN       = 3'd4
  } ctrl_state_t;

  function automatic plane_e next_plane(input plane_e p);
    case (p)
      RED:     return GREEN;
      GREEN:   return BLUE;
      default: return RED;
    endcase
  endfunction

endpackage

// File: rtl/sobel_out_fifo.sv
// Synchronous result FIFO with occupancy count; head is registered storage, no write-to-read bypass.
module sobel_out_fifo #(
  parameter  int DATA_W = 128,
  parameter  int DEPTH  = 8,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              wr_en_s;
  logic              rd_en_s;

  assign full    = (count_r == CW'(DEPTH));
  assign empty   = (count_r == {CW{1'b0}});
  assign count   = count_r;
  assign rd_en_s = pop && !empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign wr_en_s = push && (!full || rd_en_s);
  assign head    = empty ? {DATA_W{1'b0}} : mem_r[rd_ptr_r];

  // Storage write; contents are don't-care until pointed at by a valid count.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (rd_en_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer ahead of sobel_filter: gathers R/G/B beats, issues credit-limited blocks, buffers results.
// Optional perf counters (stall_cycles, frame_cycles) are built when SOBEL_CTRL_PERF_EN is defined.
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter  int DATA_W    = PIX_PER_BLK * PIX_W,
  parameter  int OUT_DEPTH = 8,
  parameter  int BLK_W     = 20,
  localparam int CW        = $clog2(OUT_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BLK_W-1:0]  cfg_num_blocks,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err_overflow,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_valid,
  output logic              src_ready,
  output logic [DATA_W-1:0] flt_data_in,
  output logic              flt_valid_in,
  input  logic [DATA_W-1:0] flt_data_out,
  input  logic              flt_valid_out,
  output logic [DATA_W-1:0] snk_data,
  output logic              snk_valid,
`ifdef SOBEL_CTRL_PERF_EN
  output logic [31:0]       stall_cycles,
  output logic [31:0]       frame_cycles,
`endif
  input  logic              snk_ready
);

  ctrl_state_t       state_r, state_nx_s;
  plane_e            beat_r;
  logic [1:0]        issue_idx_r, issue_idx_nx_s;
  logic [DATA_W-1:0] stage_r [3];
  logic [BLK_W-1:0]  in_left_r, out_left_r;
  logic [CW-1:0]     inflight_r, fifo_count_s;
  logic [CW:0]       occupied_s;
  logic              fifo_full_s, fifo_empty_s;
  logic              src_accept_s, start_ok_s, enter_issue_s, done_nx_s;
  logic              has_credit_s, pop_s, res_dec_s, res_ok_s, res_err_s;

  assign src_accept_s = src_valid && src_ready;
  assign start_ok_s   = (state_r == IDLE) && start;
  assign occupied_s   = {1'b0, fifo_count_s} + {1'b0, inflight_r};
  assign has_credit_s = (occupied_s < (CW+1)'(OUT_DEPTH));
  assign snk_valid    = !fifo_empty_s;
  assign pop_s        = snk_valid && snk_ready;
  assign res_dec_s    = flt_valid_out && (inflight_r != {CW{1'b0}});
  assign res_ok_s     = res_dec_s && (!fifo_full_s || pop_s);
  assign res_err_s    = flt_valid_out && !res_ok_s;
  assign enter_issue_s = (state_r != ISSUE) && (state_nx_s == ISSUE);

  // Next-state, issue beat index and done decode.
  always_comb begin
    state_nx_s     = state_r;
    issue_idx_nx_s = 2'd0;
    done_nx_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (cfg_num_blocks == {BLK_W{1'b0}}) begin
            done_nx_s = 1'b1;
          end else begin
            state_nx_s = GATHER;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      GATHER: begin
        if (src_accept_s && (beat_r == BLUE)) begin
          state_nx_s = has_credit_s ? ISSUE : WAIT_CREDIT;
        end else begin
          state_nx_s = GATHER;
        end
      end
      WAIT_CREDIT: begin
        state_nx_s = has_credit_s ? ISSUE : WAIT_CREDIT;
      end
      ISSUE: begin
        if (issue_idx_r == 2'd2) begin
          state_nx_s = (in_left_r != {BLK_W{1'b0}}) ? GATHER : DRAIN;
        end else begin
          state_nx_s     = ISSUE;
          issue_idx_nx_s = issue_idx_r + 2'd1;
        end
      end
      DRAIN: begin
        if (out_left_r == {BLK_W{1'b0}}) begin
          state_nx_s = IDLE;
          done_nx_s  = 1'b1;
        end else begin
          state_nx_s = DRAIN;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Beat staging; only meaningful once a full R/G/B set has been gathered.
  always_ff @(posedge clk) begin
    if (src_accept_s) begin
      stage_r[beat_r] <= src_data;
    end
  end

  // Control state, block counters, credit tracking and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      beat_r       <= RED;
      issue_idx_r  <= 2'd0;
      in_left_r    <= {BLK_W{1'b0}};
      out_left_r   <= {BLK_W{1'b0}};
      inflight_r   <= {CW{1'b0}};
      busy         <= 1'b0;
      done         <= 1'b0;
      err_overflow <= 1'b0;
      src_ready    <= 1'b0;
      flt_valid_in <= 1'b0;
      flt_data_in  <= {DATA_W{1'b0}};
    end else begin
      state_r      <= state_nx_s;
      issue_idx_r  <= issue_idx_nx_s;
      busy         <= (state_nx_s != IDLE);
      done         <= done_nx_s;
      src_ready    <= (state_nx_s == GATHER);
      flt_valid_in <= (state_nx_s == ISSUE);
      flt_data_in  <= (state_nx_s == ISSUE) ? stage_r[issue_idx_nx_s] : {DATA_W{1'b0}};
      err_overflow <= err_overflow || res_err_s;

      if (start_ok_s) begin
        beat_r <= RED;
      end else if (src_accept_s) begin
        beat_r <= next_plane(beat_r);
      end

      if (start_ok_s) begin
        in_left_r <= cfg_num_blocks;
      end else if (enter_issue_s) begin
        in_left_r <= in_left_r - BLK_W'(1);
      end

      if (start_ok_s) begin
        out_left_r <= cfg_num_blocks;
      end else if (pop_s && (out_left_r != {BLK_W{1'b0}})) begin
        out_left_r <= out_left_r - BLK_W'(1);
      end

      case ({enter_issue_s, res_dec_s})
        2'b10:   inflight_r <= inflight_r + CW'(1);
        2'b01:   inflight_r <= inflight_r - CW'(1);
        default: inflight_r <= inflight_r;
      endcase
    end
  end

`ifdef SOBEL_CTRL_PERF_EN
  // Per-frame cycle and stall counters; cleared on accepted start, held while idle.
  always_ff @(posedge clk) begin
    if (rst || start_ok_s) begin
      stall_cycles <= 32'd0;
      frame_cycles <= 32'd0;
    end else if (state_r != IDLE) begin
      frame_cycles <= frame_cycles + 32'd1;
      stall_cycles <= stall_cycles + {31'd0, (state_r == WAIT_CREDIT)}
                                   + {31'd0, (snk_valid && !snk_ready)};
    end
  end
`endif

  sobel_out_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (OUT_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (res_ok_s),
    .push_data (flt_data_out),
    .pop       (pop_s),
    .head      (snk_data),
    .count     (fifo_count_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Self-checking bench for sobel_frame_ctrl with an XOR stand-in for sobel_filter.
module tb_sobel_frame_ctrl;

  localparam int DW = 128;
  localparam int BW = 20;

  logic          clk = 1'b0;
  logic          rst, start, busy, done, err_overflow;
  logic [BW-1:0] cfg;
  logic [DW-1:0] src_data, flt_data_in, flt_data_out, snk_data;
  logic          src_valid, src_ready, flt_valid_in, flt_valid_out, snk_valid, snk_ready;
  logic          model_valid, inj_valid;
  logic [DW-1:0] model_data, inj_data;
`ifdef SOBEL_CTRL_PERF_EN
  logic [31:0]   stall_cycles, frame_cycles;
`endif

  always #5 clk = ~clk;

  assign flt_valid_out = model_valid | inj_valid;
  assign flt_data_out  = inj_valid ? inj_data : model_data;

  sobel_frame_ctrl #(.DATA_W(DW), .OUT_DEPTH(8), .BLK_W(BW)) dut (
    .clk(clk), .rst(rst), .cfg_num_blocks(cfg), .start(start), .busy(busy), .done(done),
    .err_overflow(err_overflow), .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .flt_data_in(flt_data_in), .flt_valid_in(flt_valid_in), .flt_data_out(flt_data_out),
    .flt_valid_out(flt_valid_out), .snk_data(snk_data), .snk_valid(snk_valid),
`ifdef SOBEL_CTRL_PERF_EN
    .stall_cycles(stall_cycles), .frame_cycles(frame_cycles),
`endif
    .snk_ready(snk_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Filter stand-in: result = XOR of the three issued beats, two cycles after the last beat.
  typedef struct { logic [DW-1:0] d; int due; } res_t;
  res_t          res_q[$];
  res_t          r_tmp;
  logic [DW-1:0] acc;
  int            cyc = 0, run_len = 0, blocks_issued = 0, total_beats = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      res_q.delete();
      acc = '0;
      run_len = 0;
      model_valid = 1'b0;
      model_data = '0;
    end else begin
      model_valid = 1'b0;
      if (res_q.size() > 0 && res_q[0].due <= cyc) begin
        r_tmp = res_q.pop_front();
        model_valid = 1'b1;
        model_data = r_tmp.d;
      end
      if (flt_valid_in) begin
        acc ^= flt_data_in;
        run_len++;
        total_beats++;
        if (run_len == 3) begin
          r_tmp.d = acc;
          r_tmp.due = cyc + 2;
          res_q.push_back(r_tmp);
          acc = '0;
          blocks_issued++;
        end
      end else if (run_len != 0) begin
        check("flt_run_len", run_len, 3);
        run_len = 0;
      end
    end
  end

  // Sink scoreboard, done counter and busy observer.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] e_tmp;
  int            out_cnt = 0, done_cnt = 0;
  bit            busy_seen = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (snk_valid && snk_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          check("snk_unexpected", 1, 0);
        end else begin
          e_tmp = exp_q.pop_front();
          check("snk_data", snk_data, e_tmp);
        end
      end
      if (done) begin
        done_cnt++;
        check("done_busy_low", busy, 0);
      end
      if (busy) busy_seen = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_beat(input logic [DW-1:0] d);
    int n = 0;
    src_valid = 1'b1;
    src_data  = d;
    while (!src_ready && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) check("src_ready_timeout", 0, 1);
    tick();
    src_valid = 1'b0;
  endtask

  task automatic send_block(input int v, input int b, input int gap);
    logic [7:0]    bt;
    logic [DW-1:0] d [3];
    logic [DW-1:0] x = '0;
    for (int p = 0; p < 3; p++) begin
      bt   = 8'(v * 64 + b * 4 + p + 1);
      d[p] = {16{bt}};
      x   ^= d[p];
    end
    exp_q.push_back(x);
    for (int p = 0; p < 3; p++) begin
      send_beat(d[p]);
      repeat (gap) tick();
    end
  endtask

  task automatic wait_done(input int base, input int limit);
    int n = 0;
    while (done_cnt <= base && n < limit) begin
      tick();
      n++;
    end
    if (n >= limit) check("done_timeout", 0, 1);
  endtask

  task automatic check_idle_outputs();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_overflow, 0);
    check("rst_src_ready", src_ready, 0);
    check("rst_flt_valid", flt_valid_in, 0);
    check("rst_flt_data", flt_data_in, 0);
    check("rst_snk_valid", snk_valid, 0);
    check("rst_snk_data", snk_data, 0);
  endtask

  typedef struct {
    int cfg; int gap; bit restart; int exp_out; int exp_beats; bit exp_busy;
  } fvec_t;

  task automatic run_frame(input fvec_t v, input int vi);
    int b_done = done_cnt;
    int b_out  = out_cnt;
    int b_bt   = total_beats;
    busy_seen = 1'b0;
    cfg   = BW'(v.cfg);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (v.cfg == 0) begin
      check("zero_done_next_cycle", done, 1);
      check("zero_busy", busy, 0);
      tick();
    end else begin
      for (int b = 0; b < v.cfg; b++) begin
        send_block(vi, b, v.gap);
        if (v.restart && b == 0) begin
          cfg   = BW'(7);
          start = 1'b1;
          tick();
          start = 1'b0;
        end
      end
      wait_done(b_done, 2000);
    end
    repeat (4) tick();
    check("frame_out_count", out_cnt - b_out, v.exp_out);
    check("frame_flt_beats", total_beats - b_bt, v.exp_beats);
    check("frame_done_once", done_cnt - b_done, 1);
    check("frame_busy_seen", busy_seen, v.exp_busy);
    check("frame_err", err_overflow, 0);
    check("frame_exp_empty", exp_q.size(), 0);
  endtask

  fvec_t tbl [5];
  localparam logic [DW-1:0] BEAT_A = {16{8'h11}};
  localparam logic [DW-1:0] BEAT_B = {16{8'h22}};
  localparam logic [DW-1:0] BEAT_C = {16{8'h44}};

  initial begin
    int b_done, b_out, b_iss;
    tbl[0] = '{cfg: 1, gap: 0, restart: 1'b0, exp_out: 1, exp_beats: 3,  exp_busy: 1'b1};
    tbl[1] = '{cfg: 3, gap: 2, restart: 1'b1, exp_out: 3, exp_beats: 9,  exp_busy: 1'b1};
    tbl[2] = '{cfg: 0, gap: 0, restart: 1'b0, exp_out: 0, exp_beats: 0,  exp_busy: 1'b0};
    tbl[3] = '{cfg: 6, gap: 1, restart: 1'b0, exp_out: 6, exp_beats: 18, exp_busy: 1'b1};
    tbl[4] = '{cfg: 2, gap: 3, restart: 1'b0, exp_out: 2, exp_beats: 6,  exp_busy: 1'b1};

    rst = 1'b1; start = 1'b0; cfg = '0; src_valid = 1'b0; src_data = '0;
    snk_ready = 1'b1; inj_valid = 1'b0; inj_data = '0;
    tick(); tick();
    check_idle_outputs();
    rst = 1'b0;
    tick();

    // One block A,B,C: three contiguous issue beats one cycle after C, one XOR result.
    b_done = done_cnt; b_out = out_cnt;
    exp_q.push_back({16{8'h77}});
    cfg = BW'(1); start = 1'b1; tick(); start = 1'b0;
    send_beat(BEAT_A); send_beat(BEAT_B); send_beat(BEAT_C);
    check("issue0_valid", flt_valid_in, 1); check("issue0_data", flt_data_in, BEAT_A);
    tick();
    check("issue1_valid", flt_valid_in, 1); check("issue1_data", flt_data_in, BEAT_B);
    tick();
    check("issue2_valid", flt_valid_in, 1); check("issue2_data", flt_data_in, BEAT_C);
    tick();
    check("issue_end", flt_valid_in, 0);
    wait_done(b_done, 200);
    repeat (4) tick();
    check("one_blk_out", out_cnt - b_out, 1);
    check("one_blk_done", done_cnt - b_done, 1);

    for (int i = 0; i < 5; i++) run_frame(tbl[i], i + 1);

    // Credit limit: 20 blocks with a stalled sink stop after 8 issued.
    snk_ready = 1'b0;
    b_done = done_cnt; b_out = out_cnt; b_iss = blocks_issued;
    cfg = BW'(20); start = 1'b1; tick(); start = 1'b0;
    fork
      begin
        for (int b = 0; b < 20; b++) send_block(9, b, 0);
      end
      begin
        int n = 0;
        while (blocks_issued - b_iss < 8 && n < 3000) begin tick(); n++; end
        repeat (20) tick();
        check("credit_issued", blocks_issued - b_iss, 8);
        check("credit_src_ready", src_ready, 0);
        check("credit_snk_valid", snk_valid, 1);
        check("credit_busy", busy, 1);
        snk_ready = 1'b1;
      end
    join
    wait_done(b_done, 3000);
    repeat (4) tick();
    check("credit_out_count", out_cnt - b_out, 20);
    check("credit_done_once", done_cnt - b_done, 1);

    // Unexpected filter result while idle: sticky error, data dropped.
    inj_data = {16{8'hA5}}; inj_valid = 1'b1; tick(); inj_valid = 1'b0;
    check("inj_err_set", err_overflow, 1);
    repeat (5) tick();
    check("inj_err_sticky", err_overflow, 1);
    check("inj_dropped", snk_valid, 0);

    // Reset in the middle of a 10-block frame, then a fresh 2-block frame.
    b_done = done_cnt;
    cfg = BW'(10); start = 1'b1; tick(); start = 1'b0;
    for (int b = 0; b < 4; b++) send_block(12, b, 0);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    check_idle_outputs();
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    check("rst_no_done", done_cnt - b_done, 0);
    run_frame(tbl[4], 13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
